// File: rtl/cfg_iface_master.sv
// cfg_iface_master
// SoC-side initiator for the asynchronous four-phase REQ/ACK config handshake.
// Accepts one transaction at a time from a req/gnt/rvalid bus. It drives
// registered REQ, address, write-data and write-enable-bar lines, and brings the
// returning ACK into clk_i through a flip-flop synchronizer. Read data is
// sampled only while the synchronized ACK is high, so cfg_q_i never needs a
// per-bit synchronizer. A REQ-high timeout plus a recovery guard stop an
// unresponsive or unpowered accelerator from hanging the SoC bus.

module cfg_iface_master #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // synchronous SoC bus
    input  logic                  soc_req_i,
    output logic                  soc_gnt_o,
    input  logic                  soc_we_i,
    input  logic [ADDR_WIDTH-1:0] soc_addr_i,
    input  logic [DATA_WIDTH-1:0] soc_wdata_i,
    output logic                  soc_rvalid_o,
    output logic [DATA_WIDTH-1:0] soc_rdata_o,
    output logic                  soc_err_o,
    output logic                  busy_o,
    // asynchronous four-phase handshake
    output logic                  cfg_req_o,
    output logic [ADDR_WIDTH-1:0] cfg_ad_o,
    output logic                  cfg_web_o,
    output logic [DATA_WIDTH-1:0] cfg_d_o,
    input  logic                  cfg_ack_i,
    input  logic [DATA_WIDTH-1:0] cfg_q_i
);

    // FSM encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_REQ_HIGH = 3'd2;
    localparam logic [2:0] ST_REQ_LOW  = 3'd3;
    localparam logic [2:0] ST_RECOVER  = 3'd4;
    localparam logic [2:0] ST_RESP     = 3'd5;

    // A timeout value of zero turns the timeout off completely
    localparam logic            TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam int              TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    // Recovery guard: covers a full ACK round trip through the synchronizer in
    // both directions, with margin, before the bus is declared quiet.
    localparam int              GUARD_CYCLES = 2 * SYNC_STAGES + 4;
    localparam int              GD_W         = $clog2(GUARD_CYCLES);
    localparam logic [GD_W-1:0] GUARD_LAST   = GD_W'(GUARD_CYCLES - 1);
    localparam logic [GD_W-1:0] GUARD_ONE    = GD_W'(1);

    logic [2:0]             state_r;
    logic [2:0]             state_next_s;
    logic [SYNC_STAGES-1:0] ack_sync_r;
    logic                   ack_s;
    logic [TO_W-1:0]        to_cnt_r;
    logic [GD_W-1:0]        guard_cnt_r;
    logic                   err_r;
    logic [DATA_WIDTH-1:0]  rcap_r;

    logic accept_s;      // transaction accepted in Idle
    logic req_rise_s;    // Setup -> ReqHigh
    logic ack_done_s;    // ACK seen while REQ high
    logic timeout_s;     // REQ-high budget used up without ACK
    logic resp_enter_s;  // entering Resp on this edge

    assign ack_s     = ack_sync_r[SYNC_STAGES-1];
    assign soc_gnt_o = (state_r == ST_IDLE) ? soc_req_i : 1'b0;
    assign busy_o    = (state_r != ST_IDLE);

    // Multi-stage synchronizer bringing the remote ACK into clk_i
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], cfg_ack_i};
        end
    end

    // Next-state logic and the per-edge event strobes used by the datapath
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        req_rise_s   = 1'b0;
        ack_done_s   = 1'b0;
        timeout_s    = 1'b0;
        resp_enter_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A stray ACK here is ignored; Setup will not raise REQ until it clears
                if (soc_req_i) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_SETUP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                // REQ may rise only against a quiet ACK line
                if (!ack_s) begin
                    req_rise_s   = 1'b1;
                    state_next_s = ST_REQ_HIGH;
                end else begin
                    state_next_s = ST_SETUP;
                end
            end
            ST_REQ_HIGH: begin
                if (ack_s) begin
                    ack_done_s   = 1'b1;
                    state_next_s = ST_REQ_LOW;
                end else if (TO_EN && (to_cnt_r == TO_LAST)) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_RECOVER;
                end else begin
                    state_next_s = ST_REQ_HIGH;
                end
            end
            ST_REQ_LOW: begin
                if (!ack_s) begin
                    resp_enter_s = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_REQ_LOW;
                end
            end
            ST_RECOVER: begin
                if (!ack_s && (guard_cnt_r == GUARD_LAST)) begin
                    resp_enter_s = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_RECOVER;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Handshake REQ: rises once setup is done, drops on ACK or on timeout
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_req_o <= 1'b0;
        end else if (req_rise_s) begin
            cfg_req_o <= 1'b1;
        end else if (ack_done_s || timeout_s) begin
            cfg_req_o <= 1'b0;
        end else if ((state_r == ST_REQ_HIGH) || (state_r == ST_SETUP)) begin
            cfg_req_o <= cfg_req_o;
        end else begin
            cfg_req_o <= 1'b0;
        end
    end

    // Handshake address/data/web: loaded on accept, held through the full cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_ad_o  <= {ADDR_WIDTH{1'b0}};
            cfg_d_o   <= {DATA_WIDTH{1'b0}};
            cfg_web_o <= 1'b1;
        end else if (accept_s) begin
            cfg_ad_o  <= soc_addr_i;
            cfg_d_o   <= soc_wdata_i;
            cfg_web_o <= ~soc_we_i;
        end else if (state_r == ST_RESP) begin
            cfg_web_o <= 1'b1;
        end else begin
            cfg_web_o <= cfg_web_o;
        end
    end

    // Timeout counter: counts ReqHigh cycles and is zero everywhere else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (state_r == ST_REQ_HIGH) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
        end else begin
            to_cnt_r <= {TO_W{1'b0}};
        end
    end

    // Recovery guard: restarts on every late ACK and saturates at expiry
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            guard_cnt_r <= {GD_W{1'b0}};
        end else if (state_r != ST_RECOVER) begin
            guard_cnt_r <= {GD_W{1'b0}};
        end else if (ack_s) begin
            guard_cnt_r <= {GD_W{1'b0}};
        end else if (guard_cnt_r != GUARD_LAST) begin
            guard_cnt_r <= guard_cnt_r + GUARD_ONE;
        end else begin
            guard_cnt_r <= guard_cnt_r;
        end
    end

    // Error flag: set by a timeout and cleared once the response goes out
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else if (state_r == ST_RESP) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    // Read-data capture: cfg_q_i is stable while ACK is high, so one sample suffices
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rcap_r <= {DATA_WIDTH{1'b0}};
        end else if (ack_done_s && cfg_web_o) begin
            rcap_r <= cfg_q_i;
        end else begin
            rcap_r <= rcap_r;
        end
    end

    // SoC response: one-cycle rvalid; rdata/err hold until the next response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            soc_rvalid_o <= 1'b0;
            soc_rdata_o  <= {DATA_WIDTH{1'b0}};
            soc_err_o    <= 1'b0;
        end else if (resp_enter_s) begin
            soc_rvalid_o <= 1'b1;
            soc_err_o    <= err_r;
            soc_rdata_o  <= (cfg_web_o && !err_r) ? rcap_r : {DATA_WIDTH{1'b0}};
        end else begin
            soc_rvalid_o <= 1'b0;
        end
    end

endmodule

// File: doc/cfg_iface_master.md
Name: cfg_iface_master

Overview:
- SoC-side initiator for the asynchronous 4-phase config handshake (REQ/ACK with parallel address, write-data, write-enable-bar and read-data buses) used to reach the accelerator's config interface.
- Accepts single transactions from a synchronous SoC bus (req/gnt/rvalid, one outstanding).
- Drives the request side of the handshake and synchronizes the returning ACK into clk_i.
- Returns read data or write completion, with a timeout/error path for an unresponsive or unpowered accelerator.

Parameters:
- ADDR_WIDTH, 16, width of soc_addr_i / cfg_ad_o.
- DATA_WIDTH, 32, width of all data buses.
- SYNC_STAGES, 2, flip-flop stages on cfg_ack_i; legal values 2..4.
- TIMEOUT_CYCLES, 1024, max clk_i cycles in ReqHigh before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  SoC-side clock.
- rst_ni  in  1  asynchronous active-low reset.
- soc_req_i  in  1  transaction request.
- soc_gnt_o  out  1  request accepted (combinational).
- soc_we_i  in  1  1 = write, 0 = read.
- soc_addr_i  in  ADDR_WIDTH  config address.
- soc_wdata_i  in  DATA_WIDTH  write data.
- soc_rvalid_o  out  1  one-cycle completion pulse (reads and writes).
- soc_rdata_o  out  DATA_WIDTH  read data, valid with soc_rvalid_o.
- soc_err_o  out  1  timeout error, valid with soc_rvalid_o.
- busy_o  out  1  high when state != Idle.
- cfg_req_o  out  1  handshake REQ, registered.
- cfg_ad_o  out  ADDR_WIDTH  handshake address, registered.
- cfg_web_o  out  1  handshake write-enable-bar (0 = write), registered.
- cfg_d_o  out  DATA_WIDTH  handshake write data, registered.
- cfg_ack_i  in  1  handshake ACK, asynchronous.
- cfg_q_i  in  DATA_WIDTH  handshake read data, asynchronous; stable while ACK is high.

Behaviour:

Reset values:
- cfg_req_o=0, cfg_ad_o=0, cfg_web_o=1, cfg_d_o=0.
- soc_rvalid_o=0, soc_rdata_o=0, soc_err_o=0.
- ACK sync chain all 0; state Idle; timeout counter 0.

Definitions:
- ack_s = last stage of the SYNC_STAGES synchronizer on cfg_ack_i.
- cfg_q_i is sampled only when ack_s=1; it is never synchronized bitwise.

States: Idle, Setup, ReqHigh, ReqLow, Recover, Resp.

State transitions:
- Idle:
  - soc_gnt_o = soc_req_i.
  - On accept: cfg_ad_o<=soc_addr_i, cfg_d_o<=soc_wdata_i, cfg_web_o<=~soc_we_i → Setup.
- Setup:
  - One cycle with bus stable and cfg_req_o still 0; guarantees address/data setup before REQ.
  - Set cfg_req_o<=1 → ReqHigh.
- ReqHigh:
  - Timeout counter increments each cycle.
  - ack_s=1: if read, soc_rdata_o<=cfg_q_i; cfg_req_o<=0 → ReqLow.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: cfg_req_o<=0, set error flag → Recover.
- ReqLow:
  - Wait for ack_s=0 → Resp.
  - cfg_ad_o, cfg_d_o, cfg_web_o held unchanged until Resp.
- Recover:
  - Guard counter of 2*SYNC_STAGES+4 cycles; restarts whenever ack_s=1.
  - On expiry with ack_s=0 → Resp.
  - This absorbs a late ACK racing the REQ drop.
- Resp:
  - soc_rvalid_o=1 for exactly one cycle.
  - soc_err_o = error flag; soc_rdata_o = captured data for a successful read, 0 for writes and errors.
  - Clear error flag and counters; cfg_web_o<=1 → Idle.

Timing and protocol rules:
- Latency from accept to soc_rvalid_o, with remote ACK response time R cycles: 1 (Setup) + SYNC_STAGES + R + 1 + SYNC_STAGES + R' + 1.
- soc_gnt_o is 0 in every state except Idle; a new request is never accepted in the same cycle as soc_rvalid_o.
- cfg_req_o never toggles while ACK-side data is being sampled. REQ rises only when ack_s=0 (guaranteed by entry from Idle).
- An unsolicited ack_s=1 in Idle is ignored, and Setup→ReqHigh is stalled until ack_s=0.
- soc_rdata_o and soc_err_o hold their values after the pulse until the next Resp.

Reset mid-transaction:
- All outputs return to reset values asynchronously, and cfg_req_o drops.
- After reset release the block starts in Idle and obeys the ack_s=0 rule above, so a stale remote ACK cannot be mistaken for completion.

Test Plan:
- Write: soc_we_i=1, addr=0x1004, wdata=0xDEADBEEF; remote model acks after 3 cycles → cfg_ad_o=0x1004, cfg_d_o=0xDEADBEEF, cfg_web_o=0 stable from before REQ rise until after ACK fall; one soc_rvalid_o pulse, soc_err_o=0, soc_rdata_o=0.
- Read: addr=0x2010; remote presents cfg_q_i=0x12345678 with ACK → soc_rdata_o=0x12345678 on the rvalid pulse; cfg_web_o=1 throughout.
- Timeout: TIMEOUT_CYCLES=16, remote never acks → cfg_req_o falls after 16 ReqHigh cycles; soc_rvalid_o=1, soc_err_o=1, soc_rdata_o=0; next transaction completes normally.
- Late ACK: remote asserts ACK one cycle before timeout fires → no double rvalid; Recover waits for ACK low, then exactly one pulse.
- Back-to-back: soc_req_i held high for 2 reads → soc_gnt_o low from Setup through Resp; second transaction begins only after REQ/ACK are both low; each read returns its own data.
- Reset: rst_ni asserted while in ReqHigh with ACK high → cfg_req_o=0 immediately; after release, held ACK produces no rvalid and no new REQ until ACK drops.
